// File: rtl/cnt_pkg.sv
// Shared constants for the ripple down-counter slice.
package cnt_pkg;

    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/tff_neg.sv
// Falling-edge toggle flop with asynchronous active-high reset to 1.
module tff_neg (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qn
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = t ? ~state_q : state_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= 1'b1;
        end else begin
            state_q <= state_d;
        end
    end

    assign q  = state_q;
    assign qn = ~state_q;

endmodule

// File: rtl/asy_dncnt.sv
// Asynchronous ripple down counter with rising-edge sampled count, zero and wrap flags.
// Define ASY_DNCNT_WRAP_EN to build the underflow (wrap) detector; otherwise wrap is tied to 0.
module asy_dncnt
    import cnt_pkg::*;
#(
    parameter int N = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [N-1:0] q,
    output logic [N-1:0] q_s,
    output logic         zero,
    output logic         wrap
);

    logic [N-1:0] qn_w;
    logic         unused_qn;

    // Each stage above 0 is clocked by the falling edge of the previous qn,
    // i.e. it toggles when the lower bit borrows (rises 0 -> 1).
    for (genvar i = 0; i < N; i++) begin : g_stage
        if (i == 0) begin : g_first
            tff_neg u_tff (
                .clk (clk),
                .rst (rst),
                .t   (en),
                .q   (q[i]),
                .qn  (qn_w[i])
            );
        end else begin : g_rest
            tff_neg u_tff (
                .clk (qn_w[i-1]),
                .rst (rst),
                .t   (1'b1),
                .q   (q[i]),
                .qn  (qn_w[i])
            );
        end
    end

    assign unused_qn = qn_w[N-1];

    logic [N-1:0] q_s_q;
    logic [N-1:0] q_s_d;
    logic         zero_q;
    logic         zero_d;

    always_comb begin
        q_s_d  = q;
        zero_d = (q == '0);
    end

    // NOTE: reset values match the ripple stages (all-ones) so no stale count survives reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_s_q  <= '1;
            zero_q <= 1'b0;
        end else begin
            q_s_q  <= q_s_d;
            zero_q <= zero_d;
        end
    end

    assign q_s  = q_s_q;
    assign zero = zero_q;

`ifdef ASY_DNCNT_WRAP_EN
    localparam logic [N-1:0] ONES = '1;

    logic wrap_q;
    logic wrap_d;

    // zero_q already holds "previous q_s was 0", so no extra history flop is needed.
    always_comb begin
        wrap_d = zero_q && (q == ONES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_asy_dncnt.sv
// Directed table-driven bench for asy_dncnt (N=4) plus an N=6 wrap-around run.
module tb_asy_dncnt;

`ifdef ASY_DNCNT_WRAP_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    typedef struct {
        logic       en;
        logic [3:0] exp_q;
        logic       exp_zero;
        logic       exp_wrap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] q;
    logic [3:0] q_s;
    logic       zero;
    logic       wrap;

    logic       en6 = 1'b0;
    logic [5:0] q6;
    logic [5:0] q_s6;
    logic       zero6;
    logic       wrap6;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs[$];

    asy_dncnt #(.N(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .q    (q),
        .q_s  (q_s),
        .zero (zero),
        .wrap (wrap)
    );

    asy_dncnt #(.N(6)) dut6 (
        .clk  (clk),
        .rst  (rst),
        .en   (en6),
        .q    (q6),
        .q_s  (q_s6),
        .zero (zero6),
        .wrap (wrap6)
    );

    // Rising edges at 6, 16, 26, ...; falling edges at 11, 21, ...
    initial begin
        #6 clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [3:0] eq, input logic ez, input logic ew);
        vec_t v;
        v.en       = e;
        v.exp_q    = eq;
        v.exp_zero = ez;
        v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    int wraps;

    initial begin
        // Count 1110 .. 0000, then underflow to 1111 with a one-cycle wrap.
        for (int k = 1; k <= 15; k++) add(1'b1, 4'(15 - k), (k == 15), 1'b0);
        add(1'b1, 4'hF, 1'b0, WRAP_ON);
        add(1'b0, 4'hF, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) add(1'b1, 4'(15 - k), 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) add(1'b0, 4'hA, 1'b0, 1'b0);
        add(1'b1, 4'h9, 1'b0, 1'b0);
        add(1'b1, 4'h8, 1'b0, 1'b0);

        // Reset applied before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("reset q",     32'(q),     32'hF);
        check("reset q_s",   32'(q_s),   32'hF);
        check("reset zero",  32'(zero),  32'h0);
        check("reset wrap",  32'(wrap),  32'h0);
        check("reset q_s6",  32'(q_s6),  32'h3F);
        @(posedge clk);
        @(posedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en;
            @(posedge clk);
            #1;
            check($sformatf("v%0d q", i),    32'(q),    32'(vecs[i].exp_q));
            check($sformatf("v%0d q_s", i),  32'(q_s),  32'(vecs[i].exp_q));
            check($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].exp_zero));
            check($sformatf("v%0d wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
        end

        // Mid-count reset: 1000 -> 0111 on the falling edge, then a 3-unit rst pulse.
        @(negedge clk);
        #1;
        check("midrst pre q", 32'(q), 32'h7);
        rst = 1'b1;
        #1;
        check("midrst q",    32'(q),    32'hF);
        check("midrst q_s",  32'(q_s),  32'hF);
        check("midrst zero", 32'(zero), 32'h0);
        check("midrst wrap", 32'(wrap), 32'h0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post rst q_s", 32'(q_s), 32'hF);
        @(negedge clk);
        #1;
        check("post rst q", 32'(q), 32'hE);
        @(posedge clk);
        #1;
        check("post rst q_s dec", 32'(q_s), 32'hE);

        // N=6: 64 enabled falling edges from reset return to all-ones with one wrap.
        en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        #1 en6 = 1'b1;
        wraps = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (wrap6) wraps++;
            if (k == 1)  check("n6 first q_s", 32'(q_s6), 32'h3E);
            if (k == 63) check("n6 zero",      32'(zero6), 32'h1);
            if (k == 63) check("n6 q_s at 0",  32'(q_s6), 32'h0);
        end
        check("n6 q_s wrapped", 32'(q_s6), 32'h3F);
        check("n6 wrap pulse",  32'(wrap6), 32'(WRAP_ON));
        en6 = 1'b0;
        @(posedge clk);
        #1;
        check("n6 wrap drop",   32'(wrap6), 32'h0);
        check("n6 hold q_s",    32'(q_s6),  32'h3F);
        check("n6 wrap count",  32'(wraps), 32'(WRAP_ON));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
